// File: rtl/vga_plot_display.sv
// rtl/vga_plot_display.sv - pixel-plot sink with 160x120x3 framebuffer and 4x-upscaled VGA scan-out
//
// Accepts single-cycle plot writes (plot_x, plot_y, plot_colour, plot) into a
// 3-bit-per-pixel framebuffer and scans it out as 640x480@60 VGA, each stored
// pixel shown as a 4x4 block. The framebuffer is cleared after every reset.
//
// Ports:
//   clk          50 MHz system clock
//   rst_n        asynchronous active-low reset
//   plot_x/y     plot coordinate (column 8b, row 7b)
//   plot_colour  {R,G,B}
//   plot         write strobe, one write per high cycle
//   busy         high while the clear pass runs; plots are dropped
//   vga_r/g/b    8'hFF per set colour bit in the visible region, else 8'h00
//   vga_hs/vs    active-low syncs
//   vga_blank_n  high in the visible region
//   vga_clk      25 MHz pixel clock
module vga_plot_display #(
    parameter int         FB_W         = 160,
    parameter int         FB_H         = 120,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000,
    parameter int         H_VIS        = 640,
    parameter int         H_FP         = 16,
    parameter int         H_SYNC       = 96,
    parameter int         H_BP         = 48,
    parameter int         V_VIS        = 480,
    parameter int         V_FP         = 10,
    parameter int         V_SYNC       = 2,
    parameter int         V_BP         = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] plot_x,
    input  logic [6:0] plot_y,
    input  logic [2:0] plot_colour,
    input  logic       plot,
    output logic       busy,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_clk
);

    localparam int FB_SIZE = FB_W * FB_H;
    localparam int ADDR_W  = $clog2(FB_SIZE);

    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_SIZE - 1);
    localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_addr;

    logic [2:0] fb [FB_SIZE];

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [2:0]        wr_data;
    logic              plot_ok;

    logic       pix_en;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;

    logic              visible_c;
    logic              hs_c;
    logic              vs_c;
    logic [ADDR_W-1:0] s1_addr;
    logic              s1_vis;
    logic              s1_hs;
    logic              s1_vs;
    logic [2:0]        s2_data;
    logic              s2_vis;
    logic              s2_hs;
    logic              s2_vs;

    // Single write port shared between the clear pass and plot writes.
    always_comb begin
        plot_ok = plot && ({1'b0, plot_x} < 9'(FB_W)) && ({1'b0, plot_y} < 8'(FB_H));
        wr_en   = 1'b0;
        wr_addr = clr_addr;
        wr_data = CLEAR_COLOUR;
        if (state == S_CLEAR) begin
            wr_en = 1'b1;
        end else if (plot_ok) begin
            wr_en   = 1'b1;
            wr_addr = ADDR_W'(plot_y) * ADDR_W'(FB_W) + ADDR_W'(plot_x);
            wr_data = plot_colour;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            fb[wr_addr] <= wr_data;
        end
    end

    // Independent read port; a same-edge write to the same address is not seen.
    always_ff @(posedge clk) begin
        if (pix_en) begin
            s2_data <= fb[s1_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
        end else begin
            case (state)
                S_CLEAR: begin
                    clr_addr <= clr_addr + ADDR_W'(1);
                    if (clr_addr == CLR_LAST) begin
                        state <= S_RUN;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_RUN;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Pixel tick every other clk; vga_clk is the tick phase delayed one clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_en  <= 1'b0;
            vga_clk <= 1'b0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            pix_en  <= ~pix_en;
            vga_clk <= pix_en;
            if (pix_en) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
                end else begin
                    h_cnt <= h_cnt + 10'd1;
                end
            end
        end
    end

    always_comb begin
        visible_c = (h_cnt < 10'(H_VIS)) && (v_cnt < 10'(V_VIS));
        hs_c      = !((h_cnt >= HS_FIRST) && (h_cnt < HS_END));
        vs_c      = !((v_cnt >= VS_FIRST) && (v_cnt < VS_END));
    end

    // Syncs and blank travel through the same two stages as the pixel data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_addr <= '0;
            s1_vis  <= 1'b0;
            s1_hs   <= 1'b1;
            s1_vs   <= 1'b1;
            s2_vis  <= 1'b0;
            s2_hs   <= 1'b1;
            s2_vs   <= 1'b1;
        end else if (pix_en) begin
            s1_addr <= visible_c ? ADDR_W'(v_cnt[9:2]) * ADDR_W'(FB_W) + ADDR_W'(h_cnt[9:2]) : '0;
            s1_vis  <= visible_c;
            s1_hs   <= hs_c;
            s1_vs   <= vs_c;
            s2_vis  <= s1_vis;
            s2_hs   <= s1_hs;
            s2_vs   <= s1_vs;
        end
    end

    // Pins update on the clk after stage 2, i.e. on the falling edge of vga_clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_r       <= 8'h00;
            vga_g       <= 8'h00;
            vga_b       <= 8'h00;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
        end else begin
            vga_r       <= (s2_vis && s2_data[2]) ? 8'hFF : 8'h00;
            vga_g       <= (s2_vis && s2_data[1]) ? 8'hFF : 8'h00;
            vga_b       <= (s2_vis && s2_data[0]) ? 8'hFF : 8'h00;
            vga_hs      <= s2_hs;
            vga_vs      <= s2_vs;
            vga_blank_n <= s2_vis;
        end
    end

endmodule

// File: tb/tb_vga_plot_display.sv
// tb/tb_vga_plot_display.sv - scoreboard bench for vga_plot_display on a reduced raster
module tb_vga_plot_display;

    localparam int HV = 64, HF = 4, HS = 8, HB = 4;
    localparam int VV = 32, VF = 2, VS = 2, VB = 2;
    localparam int LINE_CLKS  = 2 * (HV + HF + HS + HB);
    localparam int FRAME_CLKS = LINE_CLKS * (VV + VF + VS + VB);
    localparam int LIM        = 20000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] plot_x = '0;
    logic [6:0] plot_y = '0;
    logic [2:0] plot_colour = '0;
    logic       plot = 1'b0;
    logic       busy;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_blank_n, vga_clk;

    vga_plot_display #(
        .FB_W(160), .FB_H(120), .CLEAR_COLOUR(3'b000),
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour), .plot(plot),
        .busy(busy),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n), .vga_clk(vga_clk)
    );

    always #10 clk = ~clk;

    typedef struct {
        int col;
        int row;
        int rgb;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    task automatic push(input int col, input int row, input int rgb);
        exp_t e;
        e.col = col;
        e.row = row;
        e.rgb = rgb;
        sb.push_back(e);
    endtask

    // Monitor: tracks raster position from the pins, one sample per pixel
    // (vga_clk high at the clk falling edge), and checks the scoreboard head.
    initial begin : monitor
        int   col, run, row;
        bit   fr_ok, prev_blank;
        exp_t e;
        run = 0; row = 0; fr_ok = 0; prev_blank = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                fr_ok = 0; run = 0; row = 0; prev_blank = 0;
            end else if (vga_clk) begin
                if (!vga_vs) begin
                    row = 0;
                    fr_ok = 1;
                end
                if (vga_blank_n) begin
                    col = run;
                    run++;
                    if (fr_ok && sb.size() > 0 && sb[0].col == col && sb[0].row == row) begin
                        e = sb.pop_front();
                        chk($sformatf("pix(%0d,%0d)", col, row), {8'h00, vga_r, vga_g, vga_b}, e.rgb);
                    end
                end else begin
                    if (prev_blank) row++;
                    run = 0;
                end
                prev_blank = vga_blank_n;
            end
        end
    end

    function automatic logic sig(input int sel);
        case (sel)
            0:       return !vga_hs;
            1:       return !vga_vs;
            2:       return vga_blank_n;
            default: return vga_clk;
        endcase
    endfunction

    task automatic measure(input int sel, output int act, output int per);
        int n;
        n = 0;
        while (sig(sel) && n < LIM) begin @(negedge clk); n++; end
        while (!sig(sel) && n < LIM) begin @(negedge clk); n++; end
        act = 0;
        while (sig(sel) && n < LIM) begin @(negedge clk); n++; act++; end
        per = act;
        while (!sig(sel) && n < LIM) begin @(negedge clk); n++; per++; end
        if (n >= LIM) begin
            act = -1;
            per = -1;
        end
    endtask

    task automatic do_plot(input int x, input int y, input int c);
        plot_x = 8'(x);
        plot_y = 7'(y);
        plot_colour = 3'(c);
        plot = 1'b1;
        @(negedge clk);
        plot = 1'b0;
    endtask

    task automatic release_and_count(input bit early_plot);
        int n;
        n = 0;
        @(negedge clk);
        rst_n = 1'b1;
        while (busy && n < 30000) begin
            @(negedge clk);
            n++;
            if (early_plot && n == 100) begin
                plot_x = 8'd0; plot_y = 7'd0; plot_colour = 3'b111; plot = 1'b1;
            end else begin
                plot = 1'b0;
            end
        end
        plot = 1'b0;
        chk("busy_clks", n, 19200);
    endtask

    task automatic wait_vs();
        int n;
        n = 0;
        while (vga_vs && n < LIM) begin @(negedge clk); n++; end
        chk("vs_seen", int'(!vga_vs), 1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 3 * FRAME_CLKS) begin @(negedge clk); n++; end
        chk("sb_drained", sb.size(), 0);
        sb.delete();
    endtask

    initial begin : stim
        int a, p;
        int a2, p2;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1);
        chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);
        chk("rst_hs", vga_hs, 1);
        chk("rst_vs", vga_vs, 1);
        chk("rst_blank_n", vga_blank_n, 0);
        chk("rst_vga_clk", vga_clk, 0);

        release_and_count(1'b1);

        do_plot(10, 5, 3'b100);
        do_plot(160, 0, 3'b111);
        do_plot(0, 120, 3'b111);
        do_plot(5, 5, 3'b010);
        do_plot(5, 5, 3'b001);

        wait_vs();
        push(0, 0, 32'h000000);
        push(0, 4, 32'h000000);
        push(20, 20, 32'h0000FF);
        push(23, 20, 32'h0000FF);
        push(39, 20, 32'h000000);
        push(40, 20, 32'hFF0000);
        push(43, 20, 32'hFF0000);
        push(44, 20, 32'h000000);
        push(22, 23, 32'h0000FF);
        push(41, 23, 32'hFF0000);
        push(40, 24, 32'h000000);

        fork
            wait_drain();
            begin
                measure(0, a, p);
                chk("hs_low_clks", a, 2 * HS);
                chk("hs_period", p, LINE_CLKS);
                measure(1, a2, p2);
                chk("vs_low_clks", a2, VS * LINE_CLKS);
                chk("vs_period", p2, FRAME_CLKS);
                measure(2, a, p);
                chk("blank_n_high_clks", a, 2 * HV);
                measure(3, a, p);
                chk("vga_clk_high", a, 1);
                chk("vga_clk_period", p, 2);
            end
        join

        // Reset in the middle of the red block.
        a = 0;
        while (vga_r != 8'hFF && a < 3 * FRAME_CLKS) begin @(negedge clk); a++; end
        chk("red_before_rst", vga_r, 8'hFF);
        chk("blank_before_rst", vga_blank_n, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_rgb", {vga_r, vga_g, vga_b}, 0);
        chk("mid_rst_blank_n", vga_blank_n, 0);
        chk("mid_rst_hs", vga_hs, 1);
        chk("mid_rst_vs", vga_vs, 1);
        chk("mid_rst_vga_clk", vga_clk, 0);
        chk("mid_rst_busy", busy, 1);

        release_and_count(1'b0);
        wait_vs();
        push(20, 20, 32'h000000);
        push(40, 20, 32'h000000);
        push(43, 23, 32'h000000);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
